// File: rtl/ddr2_af_cmd_reader_0_pkg.sv
// Shared DDR2 address-FIFO parameters: field widths, bit offsets, command codes
// and the queue entry payload used by the command reader.
package ddr2_af_cmd_reader_0_pkg;

    localparam int unsigned CHIP_ADDRESS   = 1;
    localparam int unsigned BANK_ADDRESS   = 2;
    localparam int unsigned ROW_ADDRESS    = 13;
    localparam int unsigned COLUMN_ADDRESS = 10;

    localparam int unsigned AF_W         = 36;
    localparam int unsigned CMD_W        = 3;
    localparam int unsigned CMD_LSB      = 32;
    localparam int unsigned CONFLICT_BIT = 35;

    // Address packing inside the FIFO word: column at the LSBs, then row, bank, chip.
    localparam int unsigned COL_LSB  = 0;
    localparam int unsigned ROW_LSB  = COL_LSB + COLUMN_ADDRESS;
    localparam int unsigned BANK_LSB = ROW_LSB + ROW_ADDRESS;
    localparam int unsigned CHIP_LSB = BANK_LSB + BANK_ADDRESS;
    localparam int unsigned ADDR_W   = CHIP_LSB + CHIP_ADDRESS;

    localparam int unsigned TBL_IDX_W = CHIP_ADDRESS + BANK_ADDRESS;
    localparam int unsigned TBL_DEPTH = 1 << TBL_IDX_W;

    localparam int unsigned CNT_W     = 2;
    localparam int unsigned Q_DEPTH   = 2;

    typedef enum logic [CMD_W-1:0] {
        AF_CMD_WRITE = 3'b100,
        AF_CMD_READ  = 3'b101
    } af_cmd_e;

    typedef struct packed {
        logic                      conflict;
        logic                      read;
        logic [CHIP_ADDRESS-1:0]   chip;
        logic [BANK_ADDRESS-1:0]   bank;
        logic [ROW_ADDRESS-1:0]    row;
        logic [COLUMN_ADDRESS-1:0] col;
    } cmd_entry_t;

    function automatic logic is_rw_cmd(input logic [CMD_W-1:0] cmd);
        return (cmd == AF_CMD_WRITE) || (cmd == AF_CMD_READ);
    endfunction

    function automatic logic [TBL_IDX_W-1:0] bank_index(
        input logic [CHIP_ADDRESS-1:0] chip,
        input logic [BANK_ADDRESS-1:0] bank
    );
        return {chip, bank};
    endfunction

endpackage

// File: rtl/ddr2_open_row_table_0.sv
// Open-row tracker: one open bit plus row per chip/bank, updated on command
// retire and cleared by a precharge-all pulse.
module ddr2_open_row_table_0
    import ddr2_af_cmd_reader_0_pkg::*;
(
    input  logic                   clk0,
    input  logic                   rst_n,
    input  logic [TBL_IDX_W-1:0]   lookup_idx,
    input  logic [ROW_ADDRESS-1:0] lookup_row,
    output logic                   page_hit_c,
    input  logic                   retire_en,
    input  logic [TBL_IDX_W-1:0]   retire_idx,
    input  logic [ROW_ADDRESS-1:0] retire_row,
    input  logic                   precharge_all
);

    logic [TBL_DEPTH-1:0]   open_q;
    logic [ROW_ADDRESS-1:0] row_tbl [TBL_DEPTH];

    // Retiring bank opens even when a precharge-all lands in the same cycle.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            open_q <= '0;
        end else begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                if (retire_en && (retire_idx == TBL_IDX_W'(i))) begin
                    open_q[i] <= 1'b1;
                end else if (precharge_all) begin
                    open_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                row_tbl[i] <= '0;
            end
        end else if (retire_en) begin
            row_tbl[retire_idx] <= retire_row;
        end
    end

    assign page_hit_c = open_q[lookup_idx] & (row_tbl[lookup_idx] == lookup_row);

endmodule

// File: rtl/ddr2_af_cmd_reader_0.sv
// Address-FIFO consumer: pops entries, decodes them into a 2-deep command queue
// and presents the head to the scheduler with a page-hit indication.
module ddr2_af_cmd_reader_0
    import ddr2_af_cmd_reader_0_pkg::*;
(
    input  logic                      clk0,
    input  logic                      rst_n,
    input  logic [AF_W-1:0]           af_addr,
    input  logic                      af_empty,
    output logic                      ctrl_af_rden,
    input  logic                      cmd_ready,
    input  logic                      precharge_all,
    output logic                      cmd_valid,
    output logic                      cmd_read,
    output logic [CHIP_ADDRESS-1:0]   cmd_chip,
    output logic [BANK_ADDRESS-1:0]   cmd_bank,
    output logic [ROW_ADDRESS-1:0]    cmd_row,
    output logic [COLUMN_ADDRESS-1:0] cmd_col,
    output logic                      cmd_conflict,
    output logic                      cmd_page_hit,
    output logic                      cmd_illegal
);

    logic                rden_en;
    logic [CNT_W-1:0]    count;
    cmd_entry_t          q_head;
    cmd_entry_t          q_tail;
    cmd_entry_t          af_entry_c;
    logic                pop_c;
    logic                legal_c;
    logic                push_c;
    logic                retire_c;
    logic                unused_bits_c;

    // Pop enable arms one cycle after reset release.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            rden_en <= 1'b0;
        end else begin
            rden_en <= 1'b1;
        end
    end

    assign pop_c        = rden_en & ~af_empty & (count < CNT_W'(Q_DEPTH));
    assign ctrl_af_rden = pop_c;

    assign legal_c  = is_rw_cmd(af_addr[CMD_LSB +: CMD_W]);
    assign push_c   = pop_c & legal_c;
    assign retire_c = cmd_valid & cmd_ready;

    assign af_entry_c.conflict = af_addr[CONFLICT_BIT];
    assign af_entry_c.read     = (af_addr[CMD_LSB +: CMD_W] == AF_CMD_READ);
    assign af_entry_c.chip     = af_addr[CHIP_LSB +: CHIP_ADDRESS];
    assign af_entry_c.bank     = af_addr[BANK_LSB +: BANK_ADDRESS];
    assign af_entry_c.row      = af_addr[ROW_LSB +: ROW_ADDRESS];
    assign af_entry_c.col      = af_addr[COL_LSB +: COLUMN_ADDRESS];

    assign unused_bits_c = ^af_addr[CMD_LSB-1:ADDR_W];

    // In-order queue: push lands in the first free slot; retire shifts tail to head.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            q_head <= '0;
            q_tail <= '0;
        end else begin
            unique case ({push_c, retire_c})
                2'b10: begin
                    if (count == '0) begin
                        q_head <= af_entry_c;
                    end else begin
                        q_tail <= af_entry_c;
                    end
                    count <= CNT_W'(count + CNT_W'(1));
                end
                2'b01: begin
                    q_head <= q_tail;
                    count  <= CNT_W'(count - CNT_W'(1));
                end
                2'b11: begin
                    // Push needs count < 2 and retire needs count > 0, so count is 1 here.
                    q_head <= af_entry_c;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            cmd_illegal <= 1'b0;
        end else begin
            cmd_illegal <= pop_c & ~legal_c;
        end
    end

    assign cmd_valid    = (count != '0);
    assign cmd_read     = q_head.read;
    assign cmd_chip     = q_head.chip;
    assign cmd_bank     = q_head.bank;
    assign cmd_row      = q_head.row;
    assign cmd_col      = q_head.col;
    assign cmd_conflict = q_head.conflict;

    ddr2_open_row_table_0 u_open_row_table (
        .clk0          (clk0),
        .rst_n         (rst_n),
        .lookup_idx    (bank_index(q_head.chip, q_head.bank)),
        .lookup_row    (q_head.row),
        .page_hit_c    (cmd_page_hit),
        .retire_en     (retire_c),
        .retire_idx    (bank_index(q_head.chip, q_head.bank)),
        .retire_row    (q_head.row),
        .precharge_all (precharge_all)
    );

endmodule

// File: tb/tb_ddr2_af_cmd_reader_0.sv
// Directed bench for the address-FIFO command reader with a FIFO model on the input.
module tb_ddr2_af_cmd_reader_0;
    import ddr2_af_cmd_reader_0_pkg::*;

    logic        clk0 = 1'b0;
    logic        rst_n = 1'b0;
    logic [35:0] af_addr = '0;
    logic        af_empty = 1'b1;
    logic        ctrl_af_rden;
    logic        cmd_ready = 1'b0;
    logic        precharge_all = 1'b0;
    logic        cmd_valid;
    logic        cmd_read;
    logic [0:0]  cmd_chip;
    logic [1:0]  cmd_bank;
    logic [12:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        cmd_conflict;
    logic        cmd_page_hit;
    logic        cmd_illegal;

    logic [35:0] fifo [$];
    int          pop_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk0 = ~clk0;

    ddr2_af_cmd_reader_0 dut (
        .clk0          (clk0),
        .rst_n         (rst_n),
        .af_addr       (af_addr),
        .af_empty      (af_empty),
        .ctrl_af_rden  (ctrl_af_rden),
        .cmd_ready     (cmd_ready),
        .precharge_all (precharge_all),
        .cmd_valid     (cmd_valid),
        .cmd_read      (cmd_read),
        .cmd_chip      (cmd_chip),
        .cmd_bank      (cmd_bank),
        .cmd_row       (cmd_row),
        .cmd_col       (cmd_col),
        .cmd_conflict  (cmd_conflict),
        .cmd_page_hit  (cmd_page_hit),
        .cmd_illegal   (cmd_illegal)
    );

    function automatic logic [35:0] mk(input logic [2:0] cmd, input logic conflict, input logic chip,
                                       input logic [1:0] bank, input logic [12:0] row, input logic [9:0] col);
        return {conflict, cmd, 6'b0, chip, bank, row, col};
    endfunction

    task automatic refresh();
        af_empty = (fifo.size() == 0);
        if (fifo.size() != 0) af_addr = fifo[0];
    endtask

    task automatic push_word(input logic [35:0] w);
        fifo.push_back(w);
        refresh();
    endtask

    // One clock: model the FIFO pop on the edge, then settle past the falling edge.
    task automatic tick();
        logic pop_now;
        @(posedge clk0);
        pop_now = ctrl_af_rden;
        #1;
        if (pop_now && fifo.size() != 0) begin
            void'(fifo.pop_front());
            pop_cnt++;
        end
        refresh();
        @(negedge clk0);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        push_word(mk(3'b101, 1'b1, 1'b1, 2'd3, 13'h1ABC, 10'h155));
        tick();
        tick();
        checks++; if (ctrl_af_rden !== 1'b0) begin errors++; $display("FAIL rst_rden got=%0b exp=0", ctrl_af_rden); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", cmd_valid); end
        checks++; if (cmd_illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal got=%0b exp=0", cmd_illegal); end
        checks++; if (dut.count !== 2'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", dut.count); end
        rst_n = 1'b1;
        #1;
        checks++; if (ctrl_af_rden !== 1'b0) begin errors++; $display("FAIL rden_first_cycle got=%0b exp=0", ctrl_af_rden); end
        tick();
        checks++; if (ctrl_af_rden !== 1'b1) begin errors++; $display("FAIL rden_second_cycle got=%0b exp=1", ctrl_af_rden); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL valid_before_pop got=%0b exp=0", cmd_valid); end
        tick();
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL valid_after_pop got=%0b exp=1", cmd_valid); end
        checks++; if ({cmd_conflict, cmd_read, cmd_chip, cmd_bank} !== {1'b1, 1'b1, 1'b1, 2'd3}) begin
            errors++; $display("FAIL first_ctrl got=%b exp=11111", {cmd_conflict, cmd_read, cmd_chip, cmd_bank}); end
        checks++; if ({cmd_row, cmd_col} !== {13'h1ABC, 10'h155}) begin
            errors++; $display("FAIL first_addr got=%h/%h exp=1abc/155", cmd_row, cmd_col); end
        checks++; if (cmd_page_hit !== 1'b0) begin errors++; $display("FAIL first_hit got=%0b exp=0", cmd_page_hit); end
        checks++; if (pop_cnt !== 1) begin errors++; $display("FAIL first_pops got=%0d exp=1", pop_cnt); end
        cmd_ready = 1'b1;
        tick();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL first_retire got=%0b exp=0", cmd_valid); end
    endtask

    task automatic test_back_to_back();
        cmd_ready = 1'b1;
        push_word(mk(3'b100, 1'b0, 1'b0, 2'd0, 13'd1, 10'd0));
        push_word(mk(3'b101, 1'b0, 1'b0, 2'd0, 13'd1, 10'd1));
        tick();
        checks++; if ({cmd_valid, cmd_read, cmd_page_hit} !== 3'b100) begin
            errors++; $display("FAIL b2b_wr_ctrl got=%b exp=100", {cmd_valid, cmd_read, cmd_page_hit}); end
        checks++; if ({cmd_row, cmd_col} !== {13'd1, 10'd0}) begin
            errors++; $display("FAIL b2b_wr_addr got=%0d/%0d exp=1/0", cmd_row, cmd_col); end
        tick();
        checks++; if ({cmd_valid, cmd_read, cmd_page_hit} !== 3'b111) begin
            errors++; $display("FAIL b2b_rd_ctrl got=%b exp=111", {cmd_valid, cmd_read, cmd_page_hit}); end
        checks++; if (cmd_col !== 10'd1) begin errors++; $display("FAIL b2b_rd_col got=%0d exp=1", cmd_col); end
        tick();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%0b exp=0", cmd_valid); end
        checks++; if (pop_cnt !== 3) begin errors++; $display("FAIL b2b_pops got=%0d exp=3", pop_cnt); end
    endtask

    task automatic test_backpressure();
        int p0;
        cmd_ready = 1'b0;
        p0 = pop_cnt;
        for (int k = 0; k < 4; k++) push_word(mk(3'b100, 1'b0, 1'b0, 2'd1, 13'(10 + k), 10'(k)));
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if ({cmd_valid, cmd_row, cmd_col} !== {1'b1, 13'd10, 10'd0}) begin
                errors++; $display("FAIL bp_hold_c%0d got=%0b/%0d/%0d exp=1/10/0", c, cmd_valid, cmd_row, cmd_col); end
        end
        checks++; if (pop_cnt - p0 !== 2) begin errors++; $display("FAIL bp_pops got=%0d exp=2", pop_cnt - p0); end
        checks++; if (dut.count !== 2'd2) begin errors++; $display("FAIL bp_count got=%0d exp=2", dut.count); end
        checks++; if (fifo.size() !== 2) begin errors++; $display("FAIL bp_fifo_left got=%0d exp=2", fifo.size()); end
        cmd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if ({cmd_valid, cmd_page_hit, cmd_row, cmd_col} !== {1'b1, 1'b0, 13'(10 + k), 10'(k)}) begin
                errors++; $display("FAIL bp_order_%0d got=%0b/%0b/%0d/%0d exp=1/0/%0d/%0d",
                                   k, cmd_valid, cmd_page_hit, cmd_row, cmd_col, 10 + k, k); end
            tick();
        end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%0b exp=0", cmd_valid); end
    endtask

    task automatic test_illegal();
        cmd_ready = 1'b1;
        push_word(mk(3'b011, 1'b0, 1'b0, 2'd2, 13'd3, 10'd9));
        push_word(mk(3'b100, 1'b0, 1'b0, 2'd2, 13'd7, 10'd3));
        tick();
        checks++; if ({cmd_illegal, cmd_valid} !== 2'b10) begin
            errors++; $display("FAIL ill_pulse got=%b exp=10", {cmd_illegal, cmd_valid}); end
        checks++; if (dut.count !== 2'd0) begin errors++; $display("FAIL ill_count got=%0d exp=0", dut.count); end
        tick();
        checks++; if ({cmd_illegal, cmd_valid} !== 2'b01) begin
            errors++; $display("FAIL ill_next got=%b exp=01", {cmd_illegal, cmd_valid}); end
        checks++; if ({cmd_bank, cmd_row, cmd_col} !== {2'd2, 13'd7, 10'd3}) begin
            errors++; $display("FAIL ill_next_addr got=%0d/%0d/%0d exp=2/7/3", cmd_bank, cmd_row, cmd_col); end
        tick();
        checks++; if ({cmd_illegal, cmd_valid} !== 2'b00) begin
            errors++; $display("FAIL ill_drain got=%b exp=00", {cmd_illegal, cmd_valid}); end
    endtask

    task automatic test_precharge_retire();
        cmd_ready = 1'b1;
        push_word(mk(3'b100, 1'b0, 1'b0, 2'd2, 13'd5, 10'd0));
        tick();
        checks++; if ({cmd_valid, cmd_page_hit} !== 2'b10) begin
            errors++; $display("FAIL pre_b2r5_first got=%b exp=10", {cmd_valid, cmd_page_hit}); end
        precharge_all = 1'b1;
        tick();
        precharge_all = 1'b0;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL pre_retired got=%0b exp=0", cmd_valid); end
        push_word(mk(3'b101, 1'b0, 1'b0, 2'd2, 13'd5, 10'd1));
        push_word(mk(3'b100, 1'b0, 1'b0, 2'd1, 13'd13, 10'd0));
        tick();
        checks++; if ({cmd_valid, cmd_bank, cmd_page_hit} !== {1'b1, 2'd2, 1'b1}) begin
            errors++; $display("FAIL pre_b2_hit got=%b exp=1101", {cmd_valid, cmd_bank, cmd_page_hit}); end
        tick();
        checks++; if ({cmd_valid, cmd_bank, cmd_page_hit} !== {1'b1, 2'd1, 1'b0}) begin
            errors++; $display("FAIL pre_b1_miss got=%b exp=1010", {cmd_valid, cmd_bank, cmd_page_hit}); end
        tick();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL pre_drain got=%0b exp=0", cmd_valid); end
    endtask

    task automatic test_reset_midop();
        cmd_ready = 1'b0;
        push_word(mk(3'b100, 1'b0, 1'b0, 2'd1, 13'd13, 10'd4));
        push_word(mk(3'b101, 1'b0, 1'b0, 2'd2, 13'd5, 10'd6));
        tick();
        tick();
        checks++; if (dut.count !== 2'd2) begin errors++; $display("FAIL mid_count got=%0d exp=2", dut.count); end
        checks++; if ({cmd_valid, cmd_page_hit} !== 2'b11) begin
            errors++; $display("FAIL mid_hit_before got=%b exp=11", {cmd_valid, cmd_page_hit}); end
        rst_n = 1'b0;
        #1;
        checks++; if ({cmd_valid, ctrl_af_rden} !== 2'b00) begin
            errors++; $display("FAIL mid_rst_now got=%b exp=00", {cmd_valid, ctrl_af_rden}); end
        checks++; if (dut.count !== 2'd0) begin errors++; $display("FAIL mid_rst_count got=%0d exp=0", dut.count); end
        push_word(mk(3'b100, 1'b0, 1'b0, 2'd1, 13'd13, 10'd4));
        push_word(mk(3'b101, 1'b0, 1'b0, 2'd2, 13'd5, 10'd6));
        tick();
        rst_n = 1'b1;
        cmd_ready = 1'b1;
        tick();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL mid_rel_valid got=%0b exp=0", cmd_valid); end
        tick();
        checks++; if ({cmd_valid, cmd_bank, cmd_row, cmd_page_hit} !== {1'b1, 2'd1, 13'd13, 1'b0}) begin
            errors++; $display("FAIL mid_b1_miss got=%0b/%0d/%0d/%0b exp=1/1/13/0", cmd_valid, cmd_bank, cmd_row, cmd_page_hit); end
        tick();
        checks++; if ({cmd_valid, cmd_bank, cmd_row, cmd_page_hit} !== {1'b1, 2'd2, 13'd5, 1'b0}) begin
            errors++; $display("FAIL mid_b2_miss got=%0b/%0d/%0d/%0b exp=1/2/5/0", cmd_valid, cmd_bank, cmd_row, cmd_page_hit); end
        tick();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL mid_drain got=%0b exp=0", cmd_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_precharge_retire();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
